// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants for the hazard scoreboard
// Purpose: timer width and forward-select encoding shared by the scoreboard files.
// Ports: none (package).
package hazard_pkg;

  // Width of each per-register load countdown; 0 means ready.
  localparam int TIMER_W = 3;

  // Forward-select code meaning "read the register file".
  localparam int FWD_RF = 0;

  // Forward stage k is reported as code k+1 so that 0 stays free for FWD_RF.
  function automatic int fwd_code(input int stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/hazard_timer.sv
// rtl/hazard_timer.sv - per-register load countdown timer
// Purpose: one register's pending-load counter; load wins over clear, clear wins over decrement.
// Ports:
//   i_clk   - clock
//   i_rst   - synchronous active-high reset, zeroes the counter
//   i_load  - accepted load targets this register: counter <= LOAD_VAL
//   i_clear - accepted ALU write targets this register: counter <= 0
//   o_timer - current counter value, non-zero while the load is pending
module hazard_timer
  import hazard_pkg::*;
#(
  parameter logic [TIMER_W-1:0] LOAD_VAL = 3'd2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_clear,
  output logic [TIMER_W-1:0] o_timer
);

  logic [TIMER_W-1:0] r_timer;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (i_load) begin
      r_timer <= LOAD_VAL;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (r_timer != '0) begin
      r_timer <= r_timer - TIMER_W'(1);
    end
  end

  assign o_timer = r_timer;

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - load-use hazard stall and forwarding select
// Purpose: tracks pending loads per register, stalls dependent instructions,
//          picks the youngest forwarding stage per source operand.
// Ports:
//   i_clk, i_rst          - clock, synchronous active-high reset
//   i_issue_valid         - instruction present in execute
//   i_src_valid/i_src_addr- per-operand read flag and register address
//   i_dst_valid/i_dst_is_load/i_dst_addr - destination write, from memory or ALU
//   i_fwd_valid/i_fwd_addr- per downstream stage ALU result (index 0 youngest)
//   i_flush               - kill the execute instruction this cycle
//   o_stall               - hold front end, insert NOP
//   o_fwd_sel             - per operand: 0 register file, k+1 forward from stage k
//   o_busy_mask           - per register pending-load flag
//   o_stall_count         - saturating stall-cycle counter
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSRC     = 3,
  parameter int NFWD     = 2,
  parameter int NREG     = 16,
  parameter int LOAD_LAT = 2,
  localparam int AW      = $clog2(NREG),
  localparam int FSW     = $clog2(NFWD + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_issue_valid,
  input  logic [NSRC-1:0]          i_src_valid,
  input  logic [NSRC-1:0][AW-1:0]  i_src_addr,
  input  logic                     i_dst_valid,
  input  logic                     i_dst_is_load,
  input  logic [AW-1:0]            i_dst_addr,
  input  logic [NFWD-1:0]          i_fwd_valid,
  input  logic [NFWD-1:0][AW-1:0]  i_fwd_addr,
  input  logic                     i_flush,
  output logic                     o_stall,
  output logic [NSRC-1:0][FSW-1:0] o_fwd_sel,
  output logic [NREG-1:0]          o_busy_mask,
  output logic [15:0]              o_stall_count
);

  logic [NREG-1:0][TIMER_W-1:0] w_timer;
  logic [NREG-1:0]              w_busy;
  logic [NREG-1:0]              w_dst_hit;
  logic                         w_hazard;
  logic                         w_accept;
  logic                         w_load_wr;
  logic                         w_alu_wr;
  logic [15:0]                  r_stall_count;

  // Address compare against every implemented register: an operand address
  // beyond NREG matches nothing and is therefore never busy.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      for (int r = 0; r < NREG; r++) begin
        if (i_src_valid[i] && (int'(i_src_addr[i]) == r) && w_busy[r]) begin
          w_hazard = 1'b1;
        end
      end
    end
  end

  assign o_stall   = i_issue_valid & ~i_flush & w_hazard;
  assign w_accept  = i_issue_valid & ~o_stall & ~i_flush;
  assign w_load_wr = w_accept & i_dst_valid & i_dst_is_load;
  assign w_alu_wr  = w_accept & i_dst_valid & ~i_dst_is_load;

  for (genvar g = 0; g < NREG; g++) begin : g_timer
    assign w_dst_hit[g] = (int'(i_dst_addr) == g);

    // A younger ALU write to a register with a pending load supersedes it.
    hazard_timer #(
      .LOAD_VAL (TIMER_W'(LOAD_LAT))
    ) u_timer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load_wr & w_dst_hit[g]),
      .i_clear (w_alu_wr & w_dst_hit[g]),
      .o_timer (w_timer[g])
    );

    assign w_busy[g] = (w_timer[g] != '0);
  end

  // Scan oldest to youngest so the youngest matching stage overwrites last.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      o_fwd_sel[i] = FSW'(FWD_RF);
      if (i_src_valid[i] && (int'(i_src_addr[i]) < NREG)) begin
        for (int k = NFWD - 1; k >= 0; k--) begin
          if (i_fwd_valid[k] && (i_fwd_addr[k] == i_src_addr[i])) begin
            o_fwd_sel[i] = FSW'(fwd_code(k));
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_count <= '0;
    end else if (o_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign o_busy_mask   = w_busy;
  assign o_stall_count = r_stall_count;

endmodule
